// File: rtl/mem_control_ws.sv
// ---------------------------------------------------------------------------
// mem_control_ws
//
// Memory decode and access sequencer for a Z80-style core. Decodes the live
// CPU address into one of three regions (internal PRAM, internal DRAM,
// external port), drives the RAM chip enables / write strobe, and holds the
// CPU in WAIT for a per-region number of wait states. External accesses run a
// req/ack handshake with a bounded timeout that raises a one-cycle bus error.
//
// Parameters
//   ADDR_W      address bus width
//   PRAM_TOP    highest PRAM address (inclusive)
//   DRAM_TOP    highest DRAM address (inclusive)
//   PRAM_WS     wait states inserted for a PRAM access
//   DRAM_WS     wait states inserted for a DRAM access
//   CNT_W       width of the wait-state and timeout counters
//   EXT_TIMEOUT cycles spent waiting for ext_ack before a bus error
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset_n   synchronous reset, active low
//   i_m1        Z80 M1, active low (opcode fetch)
//   i_mreq      Z80 MREQ, active low
//   i_wr        Z80 WR, active low
//   i_address   CPU address
//   i_ext_ack   external bridge acknowledge, active high
//   o_pram_ce   PRAM chip enable, active low
//   o_dram_ce   DRAM chip enable, active low
//   o_dram_wr   DRAM write strobe, active low
//   o_wait_n    Z80 WAIT, active low
//   o_ext_req   external access request, active high, registered
//   o_ext_we    external write, active high, registered
//   o_bus_err   one-cycle pulse on external timeout, registered
// ---------------------------------------------------------------------------
module mem_control_ws #(
   parameter int unsigned           ADDR_W      = 16,
   parameter logic [ADDR_W-1:0]     PRAM_TOP    = 16'h0FFF,
   parameter logic [ADDR_W-1:0]     DRAM_TOP    = 16'h01FF,
   parameter int unsigned           PRAM_WS     = 0,
   parameter int unsigned           DRAM_WS     = 1,
   parameter int unsigned           CNT_W       = 4,
   parameter int unsigned           EXT_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_m1,
   input  logic              i_mreq,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_ext_ack,
   output logic              o_pram_ce,
   output logic              o_dram_ce,
   output logic              o_dram_wr,
   output logic              o_wait_n,
   output logic              o_ext_req,
   output logic              o_ext_we,
   output logic              o_bus_err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_INT = 2'd1,
      S_WAIT_EXT = 2'd2,
      S_HOLD     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_PRAM_WS = CNT_W'(PRAM_WS);
   localparam logic [CNT_W-1:0] LP_DRAM_WS = CNT_W'(DRAM_WS);
   localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(EXT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_tcnt;
   logic             r_ext_req;
   logic             r_ext_we;
   logic             r_bus_err;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_tcnt_nxt;
   logic             w_ext_req_nxt;
   logic             w_ext_we_nxt;
   logic             w_bus_err_nxt;
   logic             w_wait_n;

   logic             w_is_pram;
   logic             w_is_dram;
   logic             w_is_ext;
   logic             w_mreq_act;
   logic [CNT_W-1:0] w_ws;
   logic             w_ws_nz;

   // Region decode on the live address; the sequencer only consults it while
   // in IDLE, which is what freezes the region for the rest of an access.
   assign w_is_pram  = ~i_m1 && (i_address <= PRAM_TOP);
   assign w_is_dram  =  i_m1 && (i_address <= DRAM_TOP);
   assign w_is_ext   = ~w_is_pram && ~w_is_dram;
   assign w_mreq_act = ~i_mreq;

   assign w_ws    = w_is_pram ? LP_PRAM_WS : LP_DRAM_WS;
   assign w_ws_nz = (w_ws != '0);

   // Strobes are plain decode, forced inactive while reset is held.
   assign o_pram_ce = ~(i_reset_n && w_mreq_act && w_is_pram);
   assign o_dram_ce = ~(i_reset_n && w_mreq_act && w_is_dram);
   assign o_dram_wr = ~(i_reset_n && ~i_mreq && ~i_wr);

   assign o_wait_n  = i_reset_n ? w_wait_n : 1'b1;
   assign o_ext_req = r_ext_req;
   assign o_ext_we  = r_ext_we;
   assign o_bus_err = r_bus_err;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tcnt    <= '0;
         r_ext_req <= 1'b0;
         r_ext_we  <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tcnt    <= w_tcnt_nxt;
         r_ext_req <= w_ext_req_nxt;
         r_ext_we  <= w_ext_we_nxt;
         r_bus_err <= w_bus_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_tcnt_nxt    = r_tcnt;
      w_ext_req_nxt = r_ext_req;
      w_ext_we_nxt  = r_ext_we;
      w_bus_err_nxt = 1'b0;
      w_wait_n      = 1'b1;

      case (r_state)
         S_IDLE: begin
            // WAIT asserts in the same cycle MREQ is first seen low, so the
            // first wait state is spent here rather than in WAIT_INT.
            w_wait_n = ~(w_mreq_act && (w_is_ext || w_ws_nz));
            if (w_mreq_act) begin
               if (w_is_ext) begin
                  w_state_nxt   = S_WAIT_EXT;
                  w_ext_req_nxt = 1'b1;
                  w_ext_we_nxt  = ~i_wr;
                  w_tcnt_nxt    = '0;
               end else if (w_ws_nz) begin
                  w_state_nxt = S_WAIT_INT;
                  w_cnt_nxt   = w_ws - LP_ONE;
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
         end

         S_WAIT_INT: begin
            w_wait_n = (r_cnt == '0);
            if (i_mreq) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - LP_ONE;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end

         S_WAIT_EXT: begin
            // Acknowledge releases WAIT combinationally in the ack cycle.
            w_wait_n     = i_ext_ack;
            w_ext_we_nxt = ~i_wr;
            if (i_mreq) begin
               w_state_nxt   = S_IDLE;
               w_ext_req_nxt = 1'b0;
               w_ext_we_nxt  = 1'b0;
            end else if (i_ext_ack) begin
               w_state_nxt   = S_HOLD;
               w_ext_req_nxt = 1'b0;
               w_ext_we_nxt  = 1'b0;
            end else if (r_tcnt == LP_TO_LAST) begin
               w_state_nxt   = S_HOLD;
               w_ext_req_nxt = 1'b0;
               w_ext_we_nxt  = 1'b0;
               w_bus_err_nxt = 1'b1;
            end else begin
               w_tcnt_nxt = r_tcnt + LP_ONE;
            end
         end

         S_HOLD: begin
            // Parks here until MREQ goes high so one bus cycle is one access.
            w_wait_n = 1'b1;
            if (i_mreq) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
